display_bcm_sequencer: RTL and testbench
========================================

DISPLAY_BCM_SEQUENCER -- requirements
Module: display_bcm_sequencer

Interface
REQ-001 SHALL have parameter segments, default 1, number of 3-channel segments per pixel word.
REQ-002 SHALL have parameter cyclewidth, default 8, bits per channel of the gamma-corrected input, equal to the number of bit planes.
REQ-003 SHALL have parameter columns, default 64, pixels shifted per row; column address width colbits = $clog2(columns).
REQ-004 SHALL have parameter rows, default 16, rows scanned per frame; row address width rowbits = $clog2(rows).
REQ-005 SHALL have parameter pixel_latency, default 2, cycles from pixel_col/pixel_row to the matching cpixel.
REQ-006 SHALL have parameter base_time, default 1, ENABLE cycles for bit plane 0.
REQ-007 SHALL have port clk, input, 1, sole clock, all logic on posedge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port enable, input, 1, run request.
REQ-010 SHALL have port cpixel, input, cyclewidth*3*segments, gamma-corrected pixel word from the upstream colour encoder.
REQ-011 SHALL have port pixel_col, output, colbits, column read address.
REQ-012 SHALL have port pixel_row, output, rowbits, row read address.
REQ-013 SHALL have port display_data, output, 3*segments, panel serial data.
REQ-014 SHALL have port display_clk, output, 1, panel shift clock.
REQ-015 SHALL have port display_latch, output, 1, panel latch strobe.
REQ-016 SHALL have port display_oe_n, output, 1, active-low panel output enable.
REQ-017 SHALL have port display_row, output, rowbits, row select driven to the panel.
REQ-018 SHALL have port frame_done, output, 1, one-cycle end-of-frame pulse.

Function
REQ-019 SHALL implement states IDLE, SHIFT, LATCH, ENABLE.
REQ-020 SHALL leave IDLE for SHIFT only when enable=1, starting at plane b=cyclewidth-1 and the held row.
REQ-021 SHALL, in SHIFT, drive pixel_col=k on SHIFT cycle 2k for k=0..columns-1, with pixel_row = current row.
REQ-022 SHALL drive display_data[g]=cpixel[g*cyclewidth+b] for g=0..3*segments-1 with display_clk=0 on SHIFT cycle 2k+pixel_latency, then hold display_data with display_clk=1 on cycle 2k+pixel_latency+1.
REQ-023 SHALL spend exactly 2*columns+pixel_latency cycles in SHIFT, then enter LATCH.
REQ-024 SHALL assert display_latch for exactly one LATCH cycle and load display_row with the current row in that same cycle.
REQ-025 SHALL keep display_oe_n=1 in every state except ENABLE.
REQ-026 SHALL hold display_oe_n=0 in ENABLE for exactly base_time<<b cycles; counter width SHALL be sufficient for base_time<<(cyclewidth-1) without overflow.
REQ-027 SHALL, after ENABLE with b>0, decrement b and re-enter SHIFT on the same row.
REQ-028 SHALL, after ENABLE with b=0, advance row (rows-1 wraps to 0) and reload b=cyclewidth-1.
REQ-029 SHALL pulse frame_done for one cycle on the row wrap from rows-1 to 0.
REQ-030 SHALL sample enable only at the end of ENABLE; enable=0 there returns to IDLE, the advanced row/plane held for restart; enable deassertion mid-plane SHALL NOT truncate the plane.

Reset
REQ-031 SHALL, on rst=1 at any time including mid-SHIFT or mid-ENABLE, immediately force state=IDLE, b=cyclewidth-1, row=0, pixel_col=0, pixel_row=0, display_data=0, display_clk=0, display_latch=0, display_oe_n=1, display_row=0, frame_done=0.

Verification (columns=4, rows=2, cyclewidth=2, pixel_latency=2, base_time=2, segments=1)
REQ-032 SHALL cover: enable=1, cpixel=f(col) with R channel bits = col[1:0] -> plane 1 display_data[0] sequence 0,0,1,1 on the 4 display_clk rising edges; plane 0 sequence 0,1,0,1.
REQ-033 SHALL cover: one row pass -> SHIFT 10 cycles, latch 1 cycle, display_oe_n low 4 cycles (plane 1) then 2 cycles (plane 0), display_row=0 at both latches.
REQ-034 SHALL cover: enable held 1 for 4 planes -> display_row 0 then 1, frame_done one pulse on row 1->0 wrap, no pulse on 0->1.
REQ-035 SHALL cover: enable dropped in SHIFT of plane 1 -> plane completes including full 4-cycle ENABLE, then IDLE with display_oe_n=1; re-enable resumes at plane 0 of row 0.
REQ-036 SHALL cover: rst asserted during ENABLE -> display_oe_n=1 and all outputs at reset values before the next clock edge; after release and enable=1, sequence restarts at row 0, plane 1.
REQ-037 SHALL cover: cpixel=all ones, cyclewidth=8, base_time=1 -> plane 7 ENABLE lasts 128 cycles, plane 0 lasts 1 cycle.

Source files
------------

// File: rtl/display_bcm_sequencer.sv
// Bit-plane (binary code modulation) scan sequencer for HUB75-style LED panels.
// Shifts one bit plane per row, latches it, then lights it for base_time<<plane cycles.
module display_bcm_sequencer #(
   parameter int segments      = 1,
   parameter int cyclewidth    = 8,
   parameter int columns       = 64,
   parameter int rows          = 16,
   parameter int pixel_latency = 2,
   parameter int base_time     = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic [cyclewidth*3*segments-1:0]  cpixel,
   output logic [$clog2(columns)-1:0]        pixel_col,
   output logic [$clog2(rows)-1:0]           pixel_row,
   output logic [3*segments-1:0]             display_data,
   output logic                              display_clk,
   output logic                              display_latch,
   output logic                              display_oe_n,
   output logic [$clog2(rows)-1:0]           display_row,
   output logic                              frame_done
);

   localparam int unsigned colbits   = $clog2(columns);
   localparam int unsigned rowbits   = $clog2(rows);
   localparam int unsigned NCH       = 3 * segments;
   localparam int unsigned SHIFT_LEN = 2 * columns + pixel_latency;
   localparam int unsigned SW        = $clog2(SHIFT_LEN + 1);
   localparam int unsigned ENW       = $clog2((base_time << (cyclewidth - 1)) + 1);
   localparam int unsigned PW        = (cyclewidth > 1) ? $clog2(cyclewidth) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH, ENABLE} state_t;

   state_t             state_q;
   logic [SW-1:0]      cnt_q, cnt_d, rel_q, rel_d;
   logic [PW-1:0]      plane_q;
   logic [rowbits-1:0] row_q, row_d, display_row_q;
   logic [ENW-1:0]     en_cnt_q, en_len;
   logic [colbits-1:0] pixel_col_q;
   logic [NCH-1:0]     data_q, plane_bits;
   logic               dclk_q, latch_q, oe_n_q, frame_q;
   logic               load_now, en_last, row_wrap;

   always_comb begin
      cnt_d    = cnt_q + SW'(1);
      rel_q    = cnt_q - SW'(pixel_latency);
      rel_d    = cnt_d - SW'(pixel_latency);
      // cpixel for column k arrives on SHIFT cycle 2k+pixel_latency and is shown that same cycle
      load_now = (state_q == SHIFT) && (cnt_q >= SW'(pixel_latency)) && !rel_q[0];
      en_len   = ENW'(base_time) << plane_q;
      en_last  = (en_cnt_q == en_len - ENW'(1));
      row_wrap = (row_q == rowbits'(rows - 1));
      row_d    = row_wrap ? '0 : row_q + rowbits'(1);
      plane_bits = '0;
      for (int unsigned g = 0; g < NCH; g++)
         plane_bits[g] = cpixel[g * cyclewidth + 32'(plane_q)];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         plane_q       <= PW'(cyclewidth - 1);
         row_q         <= '0;
         en_cnt_q      <= '0;
         pixel_col_q   <= '0;
         data_q        <= '0;
         dclk_q        <= 1'b0;
         latch_q       <= 1'b0;
         oe_n_q        <= 1'b1;
         display_row_q <= '0;
         frame_q       <= 1'b0;
      end else begin
         latch_q <= 1'b0;
         frame_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (enable) begin
                  state_q     <= SHIFT;
                  cnt_q       <= '0;
                  pixel_col_q <= '0;
                  dclk_q      <= 1'b0;
               end
            end
            SHIFT: begin
               if (load_now) data_q <= plane_bits;
               if (cnt_q == SW'(SHIFT_LEN - 1)) begin
                  state_q       <= LATCH;
                  latch_q       <= 1'b1;
                  display_row_q <= row_q;
                  dclk_q        <= 1'b0;
               end else begin
                  cnt_q <= cnt_d;
                  if (!cnt_d[0] && (cnt_d < SW'(2 * columns)))
                     pixel_col_q <= colbits'(cnt_d >> 1);
                  dclk_q <= (cnt_d >= SW'(pixel_latency)) && rel_d[0];
               end
            end
            LATCH: begin
               state_q  <= ENABLE;
               oe_n_q   <= 1'b0;
               en_cnt_q <= '0;
            end
            ENABLE: begin
               if (en_last) begin
                  oe_n_q <= 1'b1;
                  if (plane_q == '0) begin
                     plane_q <= PW'(cyclewidth - 1);
                     row_q   <= row_d;
                     frame_q <= row_wrap;
                  end else begin
                     plane_q <= plane_q - PW'(1);
                  end
                  if (enable) begin
                     state_q     <= SHIFT;
                     cnt_q       <= '0;
                     pixel_col_q <= '0;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  en_cnt_q <= en_cnt_q + ENW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pixel_col     = pixel_col_q;
   assign pixel_row     = row_q;
   assign display_data  = load_now ? plane_bits : data_q;
   assign display_clk   = dclk_q;
   assign display_latch = latch_q;
   assign display_oe_n  = oe_n_q;
   assign display_row   = display_row_q;
   assign frame_done    = frame_q;

endmodule

// File: tb/tb_display_bcm_sequencer.sv
// Self-checking bench: small panel (4 cols, 2 rows, 2 planes) plus an 8-plane instance for timing.
module tb_display_bcm_sequencer;

   logic       clk;
   logic       rst, enable;
   logic [5:0] cpixel;
   logic [1:0] pixel_col;
   logic [0:0] pixel_row, display_row;
   logic [2:0] display_data;
   logic       display_clk, display_latch, display_oe_n, frame_done;

   logic        rst2, en2;
   logic [23:0] cpixel2;
   logic [1:0]  pixel_col2;
   logic [0:0]  pixel_row2, display_row2;
   logic [2:0]  display_data2;
   logic        display_clk2, display_latch2, display_oe_n2, frame_done2;

   display_bcm_sequencer #(.segments(1), .cyclewidth(2), .columns(4), .rows(2),
                           .pixel_latency(2), .base_time(2)) dut (
      .clk(clk), .rst(rst), .enable(enable), .cpixel(cpixel),
      .pixel_col(pixel_col), .pixel_row(pixel_row), .display_data(display_data),
      .display_clk(display_clk), .display_latch(display_latch),
      .display_oe_n(display_oe_n), .display_row(display_row), .frame_done(frame_done));

   display_bcm_sequencer #(.segments(1), .cyclewidth(8), .columns(4), .rows(2),
                           .pixel_latency(2), .base_time(1)) dut2 (
      .clk(clk), .rst(rst2), .enable(en2), .cpixel(cpixel2),
      .pixel_col(pixel_col2), .pixel_row(pixel_row2), .display_data(display_data2),
      .display_clk(display_clk2), .display_latch(display_latch2),
      .display_oe_n(display_oe_n2), .display_row(display_row2), .frame_done(frame_done2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream pixel store: two-stage read pipeline, matching pixel_latency=2
   logic [5:0] mem [2][4];
   logic [1:0] cp0, cp1;
   logic       rp0, rp1;
   always @(posedge clk) begin
      cp0 <= pixel_col;  cp1 <= cp0;
      rp0 <= pixel_row;  rp1 <= rp0;
   end
   assign cpixel  = mem[rp1][cp1];
   assign cpixel2 = '1;

   int unsigned errors = 0, checks = 0;
   int unsigned cyc = 0;
   int unsigned dq[$], lq[$], lcq[$], lwq[$], oq[$], fq[$], oq2[$];
   int unsigned oe_rise_cyc = 0, low_run = 0, lat_run = 0, low2 = 0, nclk2 = 0, bad2 = 0;
   logic prev_dclk = 0, prev_latch = 0, prev_oe = 1, prev_oe2 = 1, prev_dclk2 = 0;

   // Event recorder: panel-side transactions observed mid-cycle
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         prev_dclk = 0; prev_latch = 0; prev_oe = 1; low_run = 0; lat_run = 0;
         oe_rise_cyc = cyc;
      end else begin
         if (display_clk && !prev_dclk) dq.push_back(32'(display_data));
         if (display_latch && !prev_latch) begin
            lq.push_back(32'(display_row));
            lcq.push_back(cyc - oe_rise_cyc);
         end
         if (display_latch) lat_run++;
         else if (prev_latch) begin lwq.push_back(lat_run); lat_run = 0; end
         if (!display_oe_n) low_run++;
         else if (!prev_oe) begin oq.push_back(low_run); low_run = 0; oe_rise_cyc = cyc; end
         if (frame_done) fq.push_back(32'(oq.size()));
         prev_dclk = display_clk; prev_latch = display_latch; prev_oe = display_oe_n;
      end
      if (!rst2) begin
         if (display_clk2 && !prev_dclk2) begin
            nclk2++;
            if (display_data2 != 3'b111) bad2++;
         end
         if (!display_oe_n2) low2++;
         else if (!prev_oe2) begin oq2.push_back(low2); low2 = 0; end
         prev_dclk2 = display_clk2; prev_oe2 = display_oe_n2;
      end
   end

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   function automatic int unsigned cur(input int sel);
      case (sel)
         0: return dq.size();
         1: return lq.size();
         2: return oq.size();
         3: return oq2.size();
         default: return (display_oe_n === 1'b0) ? 1 : 0;
      endcase
   endfunction

   task automatic wait_cnt(input string tag, input int sel, input int unsigned n, input int budget);
      for (int i = 0; i < budget && cur(sel) < n; i++) tick(1);
      chk(tag, (cur(sel) >= n) ? 1 : 0, 1);
   endtask

   task automatic clear_q;
      dq.delete(); lq.delete(); lcq.delete(); lwq.delete(); oq.delete(); fq.delete();
   endtask

   task automatic fill_mem(input bit col_in_red);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++) begin
            mem[r][c] = 6'($urandom);
            if (col_in_red) mem[r][c][1:0] = 2'(c);
         end
   endtask

   // Reference: plane order (row, bit) from top bit down, row advances after bit 0
   task automatic check_planes(input string tag, input int r0, input int b0, input int n);
      int r, b;
      logic [2:0] e;
      r = r0; b = b0;
      chk({tag, "_nwords"}, dq.size(), 32'(4 * n));
      chk({tag, "_nlatch"}, lq.size(), 32'(n));
      chk({tag, "_nruns"},  oq.size(), 32'(n));
      for (int p = 0; p < n; p++) begin
         for (int k = 0; k < 4; k++) begin
            e = {mem[r][k][4 + b], mem[r][k][2 + b], mem[r][k][b]};
            if (p * 4 + k < dq.size()) chk({tag, "_data"}, dq[p * 4 + k], 32'(e));
         end
         if (p < lq.size())  chk({tag, "_latch_row"}, lq[p], 32'(r));
         if (p < lwq.size()) chk({tag, "_latch_width"}, lwq[p], 1);
         if (p < oq.size())  chk({tag, "_oe_len"}, oq[p], 32'(2 << b));
         if (b == 0) begin r = (r + 1) % 2; b = 1; end
         else b--;
      end
   endtask

   initial begin
      rst = 1; enable = 0; rst2 = 1; en2 = 0;
      fill_mem(1'b1);
      tick(3);
      chk("reset_outputs", 32'({pixel_col, pixel_row, display_data, display_clk, display_latch,
                                display_oe_n, display_row, frame_done}), 32'(11'b00000000100));
      rst = 0;
      tick(2);
      chk("idle_no_enable", 32'({display_oe_n, display_clk, display_latch}), 32'(3'b100));

      // Two full rows with enable held; drop it during the fourth plane
      clear_q();
      enable = 1;
      wait_cnt("timeout_a_latch", 1, 4, 300);
      enable = 0;
      wait_cnt("timeout_a_oe", 2, 4, 300);
      tick(20);
      check_planes("rowpass", 0, 1, 4);
      for (int p = 1; p < 4; p++)
         if (p < lcq.size()) chk("shift_len", lcq[p], 10);
      chk("frame_done_count", fq.size(), 1);
      if (fq.size() > 0) chk("frame_done_at_wrap", fq[0], 4);
      chk("idle_after_a", 32'({display_oe_n, display_clk, display_latch}), 32'(3'b100));

      // Enable dropped mid-SHIFT: plane still completes, then idle; resume at plane 0
      clear_q();
      fill_mem(1'b0);
      enable = 1;
      wait_cnt("timeout_b_shift", 0, 1, 100);
      enable = 0;
      wait_cnt("timeout_b_oe", 2, 1, 100);
      tick(20);
      check_planes("drop_mid_shift", 0, 1, 1);
      chk("idle_oe_b", 32'(display_oe_n), 1);
      clear_q();
      enable = 1;
      wait_cnt("timeout_b2_latch", 1, 1, 100);
      enable = 0;
      wait_cnt("timeout_b2_oe", 2, 1, 100);
      tick(10);
      check_planes("resume", 0, 0, 1);
      chk("frame_done_none_b", fq.size(), 0);

      // Asynchronous reset in the middle of ENABLE (row 1, plane 1)
      clear_q();
      enable = 1;
      wait_cnt("timeout_c_enable", 4, 1, 100);
      rst = 1;
      #1;
      chk("async_reset_outputs", 32'({pixel_col, pixel_row, display_data, display_clk, display_latch,
                                      display_oe_n, display_row, frame_done}), 32'(11'b00000000100));
      tick(2);
      rst = 0;
      clear_q();
      wait_cnt("timeout_c_latch", 1, 1, 100);
      enable = 0;
      wait_cnt("timeout_c_oe", 2, 1, 100);
      tick(10);
      check_planes("after_reset", 0, 1, 1);

      // Eight-plane instance, all-ones pixels: plane 7 lasts 128 cycles down to 1 for plane 0
      rst2 = 0;
      tick(1);
      en2 = 1;
      wait_cnt("timeout_d_runs", 3, 8, 1000);
      en2 = 0;
      for (int p = 0; p < 8; p++)
         if (p < oq2.size()) chk("plane_len_cw8", oq2[p], 32'(128 >> p));
      chk("ones_data_cw8", bad2, 0);
      chk("ones_clocks_cw8", (nclk2 >= 32) ? 1 : 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
